// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared state encoding and wait-counter width for the wait-state RAM
package dm_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef logic [0:0] dm_state_t;
    localparam dm_state_t ST_IDLE = 1'b0;
    localparam dm_state_t ST_BUSY = 1'b1;

endpackage

// File: rtl/dm_ws_ram_if.sv
// rtl/dm_ws_ram_if.sv - request/response bus between a requester and the wait-state RAM
interface dm_ws_ram_if #(
    parameter int DATA_SIZE    = 32,
    parameter int MEM_SIZE_BIT = 12
);
    localparam int ADDR_W = MEM_SIZE_BIT + $clog2(DATA_SIZE / 8);

    logic                     DM_enable;
    logic                     DM_read;
    logic                     DM_write;
    logic [ADDR_W-1:0]        DM_address;
    logic [DATA_SIZE-1:0]     DM_in;
    logic [DATA_SIZE/8-1:0]   DM_be;
    logic [DATA_SIZE-1:0]     DM_out;
    logic                     DM_ready;
    logic                     DM_done;

    modport master (
        output DM_enable, DM_read, DM_write, DM_address, DM_in, DM_be,
        input  DM_out, DM_ready, DM_done
    );

    modport slave (
        input  DM_enable, DM_read, DM_write, DM_address, DM_in, DM_be,
        output DM_out, DM_ready, DM_done
    );
endinterface

// File: rtl/dm_ws_array.sv
// rtl/dm_ws_array.sv - word storage with one synchronous read port and one byte-enabled write port
module dm_ws_array #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [DATA_SIZE-1:0]   rdata,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wbe
);
    logic [DATA_SIZE-1:0] mem [0:(1<<ADDR_W)-1];

    // Only the read register is reset; the array contents survive reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < DATA_SIZE / 8; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/dm_ws_ram.sv
// rtl/dm_ws_ram.sv - single-port RAM with programmable wait states; DM_BYTE_WRITE_EN enables per-byte writes
module dm_ws_ram
    import dm_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int MEM_SIZE_BIT = 12,
    parameter int WAIT_STATE   = 2
) (
    input  logic         clock,
    input  logic         reset,
    dm_ws_ram_if.slave   bus
);
    localparam int OFF_W  = $clog2(DATA_SIZE / 8);
    localparam int ADDR_W = MEM_SIZE_BIT + OFF_W;
    localparam int BE_W   = DATA_SIZE / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_STATE[WAIT_CNT_W-1:0];

    dm_state_t               state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic                    done_q;
    logic                    rd_q;
    logic [MEM_SIZE_BIT-1:0] word_q;
    logic [DATA_SIZE-1:0]    data_q;
    logic [BE_W-1:0]         wbe;
    logic                    accept;
    logic                    complete;
    logic                    we;
    logic                    re;

    assign accept   = (state == ST_IDLE) && bus.DM_enable && (bus.DM_read || bus.DM_write);
    assign complete = (state == ST_BUSY) && (cnt == '0);
    // Gating with reset makes a reset on the completing edge abort the access.
    assign we       = complete && !rd_q && !reset;
    assign re       = complete &&  rd_q && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= complete;
            if (state == ST_IDLE) begin
                if (accept) begin
                    state <= ST_BUSY;
                    cnt   <= WAIT_INIT;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Read wins when both commands are raised together.
    always_ff @(posedge clock) begin
        if (accept) begin
            rd_q   <= bus.DM_read;
            word_q <= bus.DM_address[ADDR_W-1:OFF_W];
            data_q <= bus.DM_in;
        end
    end

`ifdef DM_BYTE_WRITE_EN
    logic [BE_W-1:0] be_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            be_q <= bus.DM_be;
        end
    end

    assign wbe = be_q;
`else
    assign wbe = '1;
`endif

    dm_ws_array #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_W    (MEM_SIZE_BIT)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .re    (re),
        .raddr (word_q),
        .rdata (bus.DM_out),
        .we    (we),
        .waddr (word_q),
        .wdata (data_q),
        .wbe   (wbe)
    );

    assign bus.DM_ready = (state == ST_IDLE);
    assign bus.DM_done  = done_q;
endmodule
